// File: rtl/stitch_pkg.sv
// -----------------------------------------------------------------------------
// stitch_pkg
// Shared types and constants for the camera ingest path of the stitching core.
//   PIX_WIDTH    : camera pixel width (24-bit RGB888)
//   DATA_WIDTH   : bus word width (128)
//   LANE_W       : bits per pixel lane inside a bus word (32 xRGB, or 16 RGB565)
//   PIX_PER_WORD : pixels packed into one bus word
//   word_t       : one bus word
//   buf_entry_t  : output buffer entry {sof, eol, data}
//   state_t      : packer framing state
// Configuration macro: PACKER_RGB565_EN selects 16-bit RGB565 lanes.
// -----------------------------------------------------------------------------
package stitch_pkg;

  localparam int PIX_WIDTH  = 24;
  localparam int DATA_WIDTH = 128;

`ifdef PACKER_RGB565_EN
  localparam int LANE_W = 16;
`else
  localparam int LANE_W = 32;
`endif

  localparam int PIX_PER_WORD = DATA_WIDTH / LANE_W;
  localparam int LANE_IDX_W   = $clog2(PIX_PER_WORD);

  typedef logic [DATA_WIDTH-1:0] word_t;

  typedef struct packed {
    logic  sof;
    logic  eol;
    word_t data;
  } buf_entry_t;

  typedef enum logic {
    WAIT_FRAME = 1'b0,
    ACTIVE     = 1'b1
  } state_t;

  // Truncating RGB888 -> RGB565 conversion {R[7:3], G[7:2], B[7:3]}.
  function automatic logic [15:0] rgb888_to_565(input logic [PIX_WIDTH-1:0] pix);
    return {pix[23:19], pix[15:10], pix[7:3]};
  endfunction

endpackage

// File: rtl/stitch_fifo2.sv
// -----------------------------------------------------------------------------
// stitch_fifo2
// Two-entry synchronous FIFO of buf_entry_t. A push while full is accepted only
// if a pop happens in the same cycle; otherwise it is ignored (caller flags it).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write request and entry
//   pop        : read request (ignored when empty)
//   dout       : head entry (meaningful only when !empty)
//   full, empty: occupancy status
// -----------------------------------------------------------------------------
module stitch_fifo2
  import stitch_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  buf_entry_t din,
  input  logic       pop,
  output buf_entry_t dout,
  output logic       full,
  output logic       empty
);

  buf_entry_t mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       do_push;
  logic       do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; count alone decides validity, so
  // the payload flops stay plain registers without a reset network.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/cmos_pixel_packer.sv
// -----------------------------------------------------------------------------
// cmos_pixel_packer
// Frames a camera stream on vsync/href, packs pixels into 128-bit words tagged
// with start-of-frame / end-of-line, and buffers them in a 2-entry FIFO.
// The camera cannot stall: words pushed into a full buffer are dropped and
// flagged on err_ovf.
// Configuration macro: PACKER_RGB565_EN (8 x RGB565 lanes instead of 4 x xRGB).
// Ports:
//   cmos_clk, rst_n              : pixel clock, asynchronous active-low reset
//   cmos_vsync/href/clken/data   : camera interface
//   wr_data/sof/eol/valid, ready : packed word stream towards the line FIFO
//   frame_done                   : 1-cycle pulse after line IMG_VDISP ends
//   err_len, err_ovf             : sticky line-length / overflow errors,
//                                  cleared on each vsync rising edge
// -----------------------------------------------------------------------------
module cmos_pixel_packer
  import stitch_pkg::*;
#(
  parameter int IMG_HDISP = 1920,
  parameter int IMG_VDISP = 1080
) (
  input  logic                 cmos_clk,
  input  logic                 rst_n,
  input  logic                 cmos_vsync,
  input  logic                 cmos_href,
  input  logic                 cmos_clken,
  input  logic [PIX_WIDTH-1:0] cmos_data,
  output word_t                wr_data,
  output logic                 wr_sof,
  output logic                 wr_eol,
  output logic                 wr_valid,
  input  logic                 wr_ready,
  output logic                 frame_done,
  output logic                 err_len,
  output logic                 err_ovf
);

  localparam logic [11:0]           HDISP_C   = 12'(IMG_HDISP);
  localparam logic [11:0]           VDISP_C   = 12'(IMG_VDISP);
  localparam logic [LANE_IDX_W-1:0] LAST_LANE = LANE_IDX_W'(PIX_PER_WORD - 1);

  state_t                state_q, state_d;
  logic                  vs_d, hr_d;
  logic [11:0]           pix_cnt, line_cnt;
  logic [LANE_IDX_W-1:0] lane_idx;
  word_t                 word_q, word_next;
  logic                  sof_pending;
  logic [LANE_W-1:0]     pix_lane;

  logic       vs_rise, hr_fall, in_frame;
  logic       accept, overrun, line_end, word_done, flush, last_line;
  logic       push, pop, drop, full, empty;
  buf_entry_t push_entry, head;

  assign vs_rise  = cmos_vsync & ~vs_d;
  assign hr_fall  = ~cmos_href & hr_d;
  // A vsync rise restarts the frame, so it masks pixel and line-end handling.
  assign in_frame = (state_q == ACTIVE) & ~vs_rise;

  assign accept    = in_frame & cmos_clken & cmos_href & (pix_cnt < HDISP_C);
  assign overrun   = in_frame & cmos_clken & cmos_href & (pix_cnt >= HDISP_C);
  assign line_end  = in_frame & hr_fall;
  assign word_done = accept & (lane_idx == LAST_LANE);
  // href is low on a line end, so a flush never coincides with word_done.
  assign flush     = line_end & (lane_idx != '0);
  assign last_line = line_end & ((line_cnt + 12'd1) == VDISP_C);

`ifdef PACKER_RGB565_EN
  assign pix_lane = rgb888_to_565(cmos_data);
`else
  assign pix_lane = {8'h00, cmos_data};
`endif

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    word_next = word_q;
    word_next[int'(lane_idx) * LANE_W +: LANE_W] = pix_lane;
  end

  always_comb begin
    push_entry.sof  = sof_pending;
    push_entry.eol  = flush | (pix_cnt == HDISP_C - 12'd1);
    push_entry.data = flush ? word_q : word_next;
  end

  assign push = word_done | flush;
  assign pop  = ~empty & wr_ready;
  assign drop = push & full & ~pop;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge cmos_clk or negedge rst_n) begin
    if (!rst_n) state_q <= WAIT_FRAME;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_FRAME: if (vs_rise) state_d = ACTIVE;
      ACTIVE:     if (!vs_rise && last_line) state_d = WAIT_FRAME;
      default:    state_d = WAIT_FRAME;
    endcase
  end

  // ----------------------------------------------------------- datapath
  always_ff @(posedge cmos_clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d        <= 1'b0;
      hr_d        <= 1'b0;
      pix_cnt     <= '0;
      line_cnt    <= '0;
      lane_idx    <= '0;
      word_q      <= '0;
      sof_pending <= 1'b0;
      err_len     <= 1'b0;
      err_ovf     <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      vs_d       <= cmos_vsync;
      hr_d       <= cmos_href;
      frame_done <= last_line;
      if (vs_rise) begin
        pix_cnt     <= '0;
        line_cnt    <= '0;
        lane_idx    <= '0;
        word_q      <= '0;
        sof_pending <= 1'b1;
        err_len     <= 1'b0;
        err_ovf     <= 1'b0;
      end else begin
        if (accept) begin
          pix_cnt <= pix_cnt + 12'd1;
          if (word_done) begin
            lane_idx <= '0;
            word_q   <= '0;
          end else begin
            lane_idx <= lane_idx + 1'b1;
            word_q   <= word_next;
          end
        end
        if (overrun) err_len <= 1'b1;
        if (line_end) begin
          pix_cnt  <= '0;
          lane_idx <= '0;
          word_q   <= '0;
          line_cnt <= line_cnt + 12'd1;
          if (pix_cnt != HDISP_C) err_len <= 1'b1;
        end
        // A dropped sof word leaves sof_pending for the next word that lands.
        if (push && !drop) sof_pending <= 1'b0;
        if (drop)          err_ovf     <= 1'b1;
      end
    end
  end

  stitch_fifo2 u_fifo (
    .clk   (cmos_clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // Head payload is gated so the outputs read zero whenever nothing is valid.
  assign wr_valid = ~empty;
  assign wr_data  = empty ? '0 : head.data;
  assign wr_sof   = ~empty & head.sof;
  assign wr_eol   = ~empty & head.eol;

endmodule

// File: tb/tb_cmos_pixel_packer.sv
// -----------------------------------------------------------------------------
// tb_cmos_pixel_packer
// Directed bench for cmos_pixel_packer with IMG_HDISP=8, IMG_VDISP=2.
// Accepted output words are logged on the falling edge and compared against
// hand-computed words. Build with PACKER_RGB565_EN to run the RGB565 frame.
// -----------------------------------------------------------------------------
module tb_cmos_pixel_packer;

  localparam int HD = 8;
  localparam int VD = 2;

  logic         cmos_clk   = 1'b0;
  logic         rst_n      = 1'b0;
  logic         cmos_vsync = 1'b0;
  logic         cmos_href  = 1'b0;
  logic         cmos_clken = 1'b0;
  logic [23:0]  cmos_data  = '0;
  logic         wr_ready   = 1'b1;
  logic [127:0] wr_data;
  logic         wr_sof, wr_eol, wr_valid, frame_done, err_len, err_ovf;

  int           tests_run    = 0;
  int           tests_failed = 0;
  int           fd_cnt       = 0;
  logic [129:0] words[$];

  cmos_pixel_packer #(.IMG_HDISP(HD), .IMG_VDISP(VD)) dut (
    .cmos_clk   (cmos_clk),
    .rst_n      (rst_n),
    .cmos_vsync (cmos_vsync),
    .cmos_href  (cmos_href),
    .cmos_clken (cmos_clken),
    .cmos_data  (cmos_data),
    .wr_data    (wr_data),
    .wr_sof     (wr_sof),
    .wr_eol     (wr_eol),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .frame_done (frame_done),
    .err_len    (err_len),
    .err_ovf    (err_ovf)
  );

  always #5 cmos_clk = ~cmos_clk;

  // Inputs only change 1 ns after a rising edge, so the falling edge sees
  // exactly what the next rising edge will act on.
  always @(negedge cmos_clk) begin
    if (wr_valid && wr_ready) words.push_back({wr_sof, wr_eol, wr_data});
    if (frame_done) fd_cnt++;
  end

  task automatic check(input string tag, input logic [129:0] got, input logic [129:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [129:0] exp);
    if (words.size() == 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s: got no word expected %h", tag, exp);
    end else begin
      check(tag, words.pop_front(), exp);
    end
  endtask

  function automatic logic [129:0] mk(input logic sof, input logic eol,
                                      input logic [23:0] p3, input logic [23:0] p2,
                                      input logic [23:0] p1, input logic [23:0] p0);
    return {sof, eol, 8'h00, p3, 8'h00, p2, 8'h00, p1, 8'h00, p0};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge cmos_clk);
    #1;
  endtask

  task automatic frame_start();
    cmos_vsync = 1'b1;
    tick(2);
    cmos_vsync = 1'b0;
    tick(2);
  endtask

  task automatic send_pixel(input logic [23:0] p);
    cmos_href  = 1'b1;
    cmos_clken = 1'b1;
    cmos_data  = p;
    tick(1);
  endtask

  task automatic end_line();
    cmos_href  = 1'b0;
    cmos_clken = 1'b0;
    cmos_data  = '0;
    tick(3);
  endtask

  task automatic send_line(input int n, input logic [23:0] first);
    for (int i = 0; i < n; i++) send_pixel(first + 24'(i));
    end_line();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    check("reset_data", 130'(wr_data), '0);
    check("reset_flags", 130'({wr_valid, wr_sof, wr_eol, frame_done, err_len, err_ovf}), '0);
    rst_n = 1'b1;
    tick(2);

`ifdef PACKER_RGB565_EN
    // Lane 0 = 0xFF8040 -> 0xFC08; pixels 1..7 have B<8, R=G=0 -> 0.
    frame_start();
    send_pixel(24'hFF8040);
    for (int i = 1; i < 8; i++) send_pixel(24'(i));
    end_line();
    send_line(8, 24'h000000);
    tick(4);
    check("r565_count", 130'(words.size()), 130'd2);
    check_word("r565_w0", {1'b1, 1'b1, 128'h0000_FC08});
    check_word("r565_w1", {1'b0, 1'b1, 128'h0});
    check("r565_fd", 130'(fd_cnt), 130'd1);
    check("r565_err", 130'({err_len, err_ovf}), '0);
`else
    // Frame 1: two nominal lines.
    frame_start();
    send_line(8, 24'h000001);
    send_line(8, 24'h000009);
    tick(4);
    check("f1_count", 130'(words.size()), 130'd4);
    check_word("f1_w0", mk(1, 0, 24'h4, 24'h3, 24'h2, 24'h1));
    check_word("f1_w1", mk(0, 1, 24'h8, 24'h7, 24'h6, 24'h5));
    check_word("f1_w2", mk(0, 0, 24'hC, 24'hB, 24'hA, 24'h9));
    check_word("f1_w3", mk(0, 1, 24'h10, 24'hF, 24'hE, 24'hD));
    check("f1_fd", 130'(fd_cnt), 130'd1);
    check("f1_err", 130'({err_len, err_ovf}), '0);

    // Frame 2: short first line flushes a half word with eol.
    frame_start();
    send_line(6, 24'h000011);
    check("f2_err_len", 130'(err_len), 130'd1);
    send_line(8, 24'h000021);
    tick(4);
    check("f2_count", 130'(words.size()), 130'd4);
    check_word("f2_w0", mk(1, 0, 24'h14, 24'h13, 24'h12, 24'h11));
    check_word("f2_w1", mk(0, 1, 24'h0, 24'h0, 24'h16, 24'h15));
    check_word("f2_w2", mk(0, 0, 24'h24, 24'h23, 24'h22, 24'h21));
    check_word("f2_w3", mk(0, 1, 24'h28, 24'h27, 24'h26, 24'h25));
    check("f2_fd", 130'(fd_cnt), 130'd2);

    // Frame 3: vsync clears err_len; long first line drops pixels 9-10.
    frame_start();
    check("f3_err_clr", 130'(err_len), 130'd0);
    send_line(10, 24'h000031);
    check("f3_err_len", 130'(err_len), 130'd1);
    send_line(8, 24'h000041);
    tick(4);
    check("f3_count", 130'(words.size()), 130'd4);
    check_word("f3_w0", mk(1, 0, 24'h34, 24'h33, 24'h32, 24'h31));
    check_word("f3_w1", mk(0, 1, 24'h38, 24'h37, 24'h36, 24'h35));
    check_word("f3_w2", mk(0, 0, 24'h44, 24'h43, 24'h42, 24'h41));
    check_word("f3_w3", mk(0, 1, 24'h48, 24'h47, 24'h46, 24'h45));

    // Frame 4: consumer stalled; buffer fills, next line's words drop.
    frame_start();
    wr_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send_pixel(24'h51 + 24'(i));
      if (i == 2) check("f4_lat_before", 130'(wr_valid), 130'd0);
      if (i == 3) check("f4_lat_after", 130'(wr_valid), 130'd1);
    end
    end_line();
    check("f4_valid", 130'(wr_valid), 130'd1);
    check("f4_no_ovf", 130'(err_ovf), 130'd0);
    send_line(8, 24'h000059);
    check("f4_ovf", 130'(err_ovf), 130'd1);
    check("f4_held", 130'(words.size()), 130'd0);
    wr_ready = 1'b1;
    tick(4);
    check("f4_count", 130'(words.size()), 130'd2);
    check_word("f4_w0", mk(1, 0, 24'h54, 24'h53, 24'h52, 24'h51));
    check_word("f4_w1", mk(0, 1, 24'h58, 24'h57, 24'h56, 24'h55));
    check("f4_fd", 130'(fd_cnt), 130'd4);

    // Frame 5: reset mid-line; the rest of that frame is ignored.
    frame_start();
    for (int i = 0; i < 5; i++) send_pixel(24'h61 + 24'(i));
    rst_n = 1'b0;
    tick(2);
    check("f5_rst_flags", 130'({wr_valid, frame_done, err_len, err_ovf}), '0);
    rst_n = 1'b1;
    check("f5_pre_reset", 130'(words.size()), 130'd1);
    words.delete();
    for (int i = 0; i < 3; i++) send_pixel(24'h66 + 24'(i));
    end_line();
    send_line(8, 24'h000069);
    tick(4);
    check("f5_ignored", 130'({words.size() != 0, wr_valid}), '0);
    frame_start();
    send_line(8, 24'h000071);
    send_line(8, 24'h000079);
    tick(4);
    check("f6_count", 130'(words.size()), 130'd4);
    check_word("f6_w0", mk(1, 0, 24'h74, 24'h73, 24'h72, 24'h71));
    check("f6_fd", 130'(fd_cnt), 130'd5);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cmos_pixel_packer.md
Name: cmos_pixel_packer

Overview:
- Ingest stage between one sim_cmos/camera source and the stitching core's write path (line FIFO feeding the AXI write master).
- Runs entirely in cmos_clk. Frames on vsync/href, packs 24-bit RGB pixels into 128-bit bus words, and tags each word with start-of-frame and end-of-line.
- Camera cannot stall, so backpressure is absorbed by a 2-deep output buffer; excess is dropped and flagged.

Parameters:
- IMG_HDISP, 1920, active pixels per line (expected)
- IMG_VDISP, 1080, active lines per frame (expected)
- DATA_WIDTH, 128, output word width; fixed at 128
- PIX_WIDTH, 24, input pixel width; fixed at 24

Ports:
- cmos_clk  in  1  pixel clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmos_vsync  in  1  frame sync, active high; rising edge = frame start
- cmos_href  in  1  line valid, active high
- cmos_clken  in  1  pixel strobe; qualified by cmos_href
- cmos_data  in  24  pixel {R[23:16],G[15:8],B[7:0]}
- wr_data  out  128  packed word
- wr_sof  out  1  word is first of frame
- wr_eol  out  1  word is last of line
- wr_valid  out  1  word available
- wr_ready  in  1  consumer accepts word when wr_valid&wr_ready
- frame_done  out  1  one-cycle pulse at end of line IMG_VDISP
- err_len  out  1  sticky: a line length was not IMG_HDISP
- err_ovf  out  1  sticky: a word was dropped (buffer full)

Behaviour:
- Reset: all outputs 0, buffer empty, state WAIT_FRAME, counters 0.
- Reset deassertion mid-frame: input ignored until the next vsync rising edge.
- Edges: vsync/href registered once (vs_d, hr_d). Rising edge = cur&~d; falling edge = ~cur&d.
- State WAIT_FRAME -> ACTIVE on vsync rise.
- ACTIVE on vsync rise:
  - pix_cnt, line_cnt and lane index cleared; partial word discarded.
  - sof_pending set; err_len and err_ovf cleared.
  - Stays ACTIVE.
- Pixel accept: cmos_clken & cmos_href & pix_cnt<IMG_HDISP. clken with href low is ignored.
- Pixel 0 of word occupies bits [31:0]; lane = {8'h00,R,G,B}; 4 pixels per word.
- Word completes on 4th accepted pixel and is pushed the same cycle; wr_valid rises next cycle (latency 1).
- Pushed word carries wr_sof=sof_pending (then cleared) and wr_eol=(pix_cnt==IMG_HDISP-1).
- Line end on href falling edge:
  - Partial word present: flushed with unused lanes zero and eol=1.
  - Any accepted pixels beyond IMG_HDISP are dropped; err_len set.
  - pix_cnt!=IMG_HDISP: err_len set. A short line ending on a word boundary therefore carries no eol.
  - line_cnt increments; if the new value equals IMG_VDISP, frame_done pulses next cycle and state -> WAIT_FRAME.
- A flush and a word completion are never in the same cycle: clken is unqualified while href is low.
- Buffer: 2-entry FIFO of {sof,eol,data}.
  - wr_valid = not empty.
  - Push and pop in the same cycle when full: allowed, no drop.
  - Push when full without pop: word dropped, err_ovf set.
  - A dropped sof word leaves sof_pending set for the next pushed word.
- Counters: pix_cnt 12 bits, line_cnt 12 bits. No wrap within legal frames; extra lines after IMG_VDISP are ignored (WAIT_FRAME).

Optional Feature:
- Macro PACKER_RGB565_EN.
- Defined:
  - Each pixel is converted to {R[7:3],G[7:2],B[7:3]}.
  - 8 pixels per word, 16-bit lanes, pixel 0 in [15:0].
  - Completion on the 8th pixel; flush, eol and error rules unchanged.
- Undefined: 32-bit xRGB lanes, 4 per word as above.

Decomposition:
- Package stitch_pkg:
  - PIX_WIDTH, LANE_W (32 or 16 via macro), PIX_PER_WORD.
  - typedef word_t logic[127:0].
  - typedef buf_entry_t struct {sof,eol,word_t}.
  - function rgb888_to_565.
- Sub-module stitch_fifo2: 2-entry synchronous FIFO of buf_entry_t, async active-low reset, with full/empty outputs.

Test Plan:
- IMG_HDISP=8, IMG_VDISP=2, wr_ready=1, pixels 0x000001..0x000010: expect 4 words, e.g. word0=0x00000004_00000003_00000002_00000001.
  - Flags: word0 sof=1; word1 and word3 eol=1.
  - frame_done pulses once; err_len=err_ovf=0.
- Line of 6 pixels (IMG_HDISP=8): expect word1 lanes 2-3 = 0, eol=1, err_len=1; err_len clears on the next vsync rise.
- Line of 10 pixels: expect pixels 9-10 dropped, 2 words, second with eol=1, err_len=1.
- wr_ready=0 for an entire 8-pixel line:
  - Words 0 and 1 buffered, wr_valid=1.
  - First word of the next line dropped, err_ovf=1.
  - Raising wr_ready then drains 2 words in order.
- Reset asserted mid-line, released mid-frame: no output until the next vsync rise; first word after it has sof=1.
- With PACKER_RGB565_EN, pixel 0xFF8040 in lane 0: expect [15:0]=0xFC08; a full line of 8 pixels yields 1 word with sof=1, eol=1.
